// File: rtl/wb_trace_fifo.sv
// Write-back trace buffer: first-word-fall-through FIFO of {PC, data, seq} commits
// with a shared sequence space and a sticky overflow / saturating drop counter.
module wb_trace_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int SEQ_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              RegWriteCommand,
   input  logic [31:0]       WriteData,
   input  logic [31:0]       ProgramCount,
   input  logic              Pop,
   output logic              OutValid,
   output logic [31:0]       OutPC,
   output logic [31:0]       OutData,
   output logic [SEQ_W-1:0]  OutSeq,
   output logic [ADDR_W:0]   Count,
   output logic              Empty,
   output logic              Full,
   output logic              Overflow,
   output logic [7:0]        DropCount
);

   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_e;

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      data;
      logic [SEQ_W-1:0] seq;
   } entry_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   entry_t              mem_q [DEPTH];
   entry_t              head;
   occ_e                state_q;
   logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]     count_q, count_d;
   logic [SEQ_W-1:0]    seq_q;
   logic                overflow_q;
   logic [7:0]          drop_q;
   logic                pop_eff, push_ok, drop;

   always_comb begin
      // A full FIFO still accepts a commit when the same edge frees the head slot.
      pop_eff = Pop && (state_q != ST_EMPTY);
      push_ok = RegWriteCommand && ((state_q != ST_FULL) || pop_eff);
      drop    = RegWriteCommand && !push_ok;
      count_d = count_q;
      case ({push_ok, pop_eff})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: the storage array has no reset; its contents are only observed behind a valid pointer.
   always_ff @(posedge Clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= '{pc: ProgramCount, data: WriteData, seq: seq_q};
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= ST_EMPTY;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         count_q <= count_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
         if (pop_eff) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
         if (RegWriteCommand) seq_q <= seq_q + SEQ_W'(1);
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
         end
         case (state_q)
            ST_EMPTY:   if (push_ok) state_q <= ST_PARTIAL;
            ST_PARTIAL: begin
               if (push_ok && !pop_eff && count_q == DEPTH_C - 1'b1) state_q <= ST_FULL;
               else if (pop_eff && !push_ok && count_q == (ADDR_W + 1)'(1)) state_q <= ST_EMPTY;
            end
            ST_FULL:    if (pop_eff && !push_ok) state_q <= ST_PARTIAL;
            default:    state_q <= ST_EMPTY;
         endcase
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign Empty     = (state_q == ST_EMPTY);
   assign Full      = (state_q == ST_FULL);
   assign OutValid  = !Empty;
   assign OutPC     = OutValid ? head.pc   : '0;
   assign OutData   = OutValid ? head.data : '0;
   assign OutSeq    = OutValid ? head.seq  : '0;
   assign Count     = count_q;
   assign Overflow  = overflow_q;
   assign DropCount = drop_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_wb_trace_fifo;

   localparam int DEPTH = 16;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        RegWriteCommand;
   logic [31:0] WriteData, ProgramCount;
   logic        Pop;
   logic        OutValid, Empty, Full, Overflow;
   logic [31:0] OutPC, OutData;
   logic [15:0] OutSeq;
   logic [4:0]  Count;
   logic [7:0]  DropCount;

   int n_cmp = 0;
   int n_err = 0;

   wb_trace_fifo #(.DEPTH(16), .ADDR_W(4), .SEQ_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .RegWriteCommand(RegWriteCommand),
      .WriteData(WriteData), .ProgramCount(ProgramCount), .Pop(Pop),
      .OutValid(OutValid), .OutPC(OutPC), .OutData(OutData), .OutSeq(OutSeq),
      .Count(Count), .Empty(Empty), .Full(Full), .Overflow(Overflow),
      .DropCount(DropCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic [15:0] seq;
   } ent_t;

   ent_t mq[$];
   int   m_seq;
   int   m_drops;
   bit   m_ovf;

   function automatic void model_reset();
      mq.delete();
      m_seq   = 0;
      m_drops = 0;
      m_ovf   = 1'b0;
   endfunction

   // Drive one cycle of stimulus, advance the model at the edge, settle 1 time unit after it.
   task automatic step(input bit cmd, input logic [31:0] pc, input logic [31:0] data, input bit pop);
      bit   pop_eff;
      ent_t e;
      RegWriteCommand = cmd;
      ProgramCount    = pc;
      WriteData       = data;
      Pop             = pop;
      @(posedge Clk);
      pop_eff = pop && (mq.size() > 0);
      if (pop_eff) void'(mq.pop_front());
      if (cmd) begin
         if (mq.size() < DEPTH) begin
            e.pc = pc; e.data = data; e.seq = 16'(m_seq);
            mq.push_back(e);
         end else begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
         m_seq = (m_seq + 1) % 65536;
      end
      #1;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      RegWriteCommand = 1'b0; Pop = 1'b0; WriteData = '0; ProgramCount = '0;
      repeat (2) @(posedge Clk);
      #2 Reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      RegWriteCommand = 1'b0; Pop = 1'b0; WriteData = '0; ProgramCount = '0;
      repeat (4) @(posedge Clk);
      #2 Reset = 1'b0;
      model_reset();
      n_cmp++;
      if ({OutValid, Empty, Full, Overflow} !== 4'b0100 || Count !== 5'd0 || DropCount !== 8'd0 ||
          OutPC !== 32'h0 || OutData !== 32'h0 || OutSeq !== 16'h0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b empty=%b full=%b ovf=%b cnt=%0d drop=%0d pc=%h data=%h seq=%h, expected 0/1/0/0/0/0/0/0/0",
                  OutValid, Empty, Full, Overflow, Count, DropCount, OutPC, OutData, OutSeq);
      end
   endtask

   task automatic test_first_commit();
      step(1'b1, 32'h4, 32'h2A, 1'b0);
      n_cmp++;
      if (OutValid !== 1'b1 || OutPC !== 32'h4 || OutData !== 32'h2A || OutSeq !== 16'd0 || Count !== 5'd1) begin
         n_err++;
         $display("FAIL first_commit: got valid=%b pc=%h data=%h seq=%0d cnt=%0d, expected 1/4/2a/0/1",
                  OutValid, OutPC, OutData, OutSeq, Count);
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 32'(4 * i), 32'(i), 1'b0);
      n_cmp++;
      if (Full !== 1'b1 || Count !== 5'd16 || Empty !== 1'b0) begin
         n_err++;
         $display("FAIL fill_full: got full=%b cnt=%0d empty=%b, expected 1/16/0", Full, Count, Empty);
      end
      step(1'b1, 32'h40, 32'd16, 1'b0);
      n_cmp++;
      if (Overflow !== 1'b1 || DropCount !== 8'd1 || Count !== 5'd16) begin
         n_err++;
         $display("FAIL overflow_17th: got ovf=%b drop=%0d cnt=%0d, expected 1/1/16", Overflow, DropCount, Count);
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (OutValid !== 1'b1 || OutSeq !== 16'(i) || OutData !== 32'(i) || OutPC !== 32'(4 * i)) begin
            n_err++;
            $display("FAIL drain_order[%0d]: got valid=%b seq=%0d data=%0d pc=%h, expected 1/%0d/%0d/%h",
                     i, OutValid, OutSeq, OutData, OutPC, i, i, 4 * i);
         end
         step(1'b0, 32'h0, 32'h0, 1'b1);
      end
      n_cmp++;
      if (Empty !== 1'b1 || Count !== 5'd0 || OutValid !== 1'b0) begin
         n_err++;
         $display("FAIL drained_empty: got empty=%b cnt=%0d valid=%b, expected 1/0/0", Empty, Count, OutValid);
      end
      step(1'b1, 32'h100, 32'hBEEF, 1'b0);
      n_cmp++;
      if (OutSeq !== 16'd17 || OutData !== 32'hBEEF) begin
         n_err++;
         $display("FAIL seq_after_drop: got seq=%0d data=%h, expected 17/beef", OutSeq, OutData);
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 32'(4 * i), 32'(100 + i), 1'b0);
      step(1'b1, 32'hF00, 32'hCAFE, 1'b1);
      n_cmp++;
      if (Count !== 5'd16 || Full !== 1'b1 || Overflow !== 1'b0 || DropCount !== 8'd0) begin
         n_err++;
         $display("FAIL full_push_pop: got cnt=%0d full=%b ovf=%b drop=%0d, expected 16/1/0/0",
                  Count, Full, Overflow, DropCount);
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (OutData !== mq[0].data || OutSeq !== mq[0].seq || OutPC !== mq[0].pc) begin
            n_err++;
            $display("FAIL full_drain[%0d]: got data=%h seq=%0d pc=%h, expected %h/%0d/%h",
                     i, OutData, OutSeq, OutPC, mq[0].data, mq[0].seq, mq[0].pc);
         end
         step(1'b0, 32'h0, 32'h0, 1'b1);
      end
      n_cmp++;
      if (Empty !== 1'b1 || Count !== 5'd0) begin
         n_err++;
         $display("FAIL full_drain_end: got empty=%b cnt=%0d, expected 1/0", Empty, Count);
      end
   endtask

   task automatic test_empty_push_pop();
      do_reset();
      step(1'b1, 32'h80, 32'h1234, 1'b1);
      n_cmp++;
      if (Count !== 5'd1 || OutValid !== 1'b1 || OutData !== 32'h1234 || OutSeq !== 16'd0) begin
         n_err++;
         $display("FAIL empty_push_pop: got cnt=%0d valid=%b data=%h seq=%0d, expected 1/1/1234/0",
                  Count, OutValid, OutData, OutSeq);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 1'b1);
      n_cmp++;
      if (Count !== 5'd0 || Empty !== 1'b1 || OutValid !== 1'b0) begin
         n_err++;
         $display("FAIL pop_while_empty: got cnt=%0d empty=%b valid=%b, expected 0/1/0", Count, Empty, OutValid);
      end
      step(1'b1, 32'h84, 32'h5678, 1'b0);
      step(1'b1, 32'h88, 32'h9ABC, 1'b0);
      n_cmp++;
      if (Count !== 5'd2 || OutData !== 32'h5678 || OutSeq !== 16'd1 || OutPC !== 32'h84) begin
         n_err++;
         $display("FAIL after_empty_pop: got cnt=%0d data=%h seq=%0d pc=%h, expected 2/5678/1/84",
                  Count, OutData, OutSeq, OutPC);
      end
   endtask

   task automatic test_saturation_async_reset();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 32'(i), 32'(i), 1'b0);
         if (i == 270) begin
            n_cmp++;
            if (DropCount !== 8'(m_drops)) begin
               n_err++;
               $display("FAIL drop_count_271: got %0d, expected %0d", DropCount, m_drops);
            end
         end
      end
      n_cmp++;
      if (DropCount !== 8'd255 || Overflow !== 1'b1 || Count !== 5'd16 || OutSeq !== 16'd0) begin
         n_err++;
         $display("FAIL saturation: got drop=%0d ovf=%b cnt=%0d seq=%0d, expected 255/1/16/0",
                  DropCount, Overflow, Count, OutSeq);
      end
      RegWriteCommand = 1'b1; Pop = 1'b1;
      #3 Reset = 1'b1;
      #1;
      n_cmp++;
      if ({OutValid, Empty, Full, Overflow} !== 4'b0100 || Count !== 5'd0 || DropCount !== 8'd0 ||
          OutPC !== 32'h0 || OutData !== 32'h0 || OutSeq !== 16'h0) begin
         n_err++;
         $display("FAIL async_reset: got valid=%b empty=%b full=%b ovf=%b cnt=%0d drop=%0d pc=%h seq=%h, expected 0/1/0/0/0/0/0/0",
                  OutValid, Empty, Full, Overflow, Count, DropCount, OutPC, OutSeq);
      end
      @(posedge Clk);
      #2 Reset = 1'b0;
      model_reset();
      step(1'b1, 32'h200, 32'h77, 1'b0);
      n_cmp++;
      if (OutSeq !== 16'd0 || Count !== 5'd1 || OutData !== 32'h77) begin
         n_err++;
         $display("FAIL post_reset_seq: got seq=%0d cnt=%0d data=%h, expected 0/1/77", OutSeq, Count, OutData);
      end
   endtask

   task automatic test_streaming();
      int prev_seq;
      do_reset();
      prev_seq = -1;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 32'(4 * i), $urandom, 1'b1);
         n_cmp++;
         if (Count > 5'd1 || OutValid !== 1'b1 || int'(OutSeq) !== prev_seq + 1 || OutData !== mq[0].data) begin
            n_err++;
            $display("FAIL streaming[%0d]: got cnt=%0d valid=%b seq=%0d data=%h, expected <=1/1/%0d/%h",
                     i, Count, OutValid, OutSeq, OutData, prev_seq + 1, mq[0].data);
         end
         prev_seq = int'(OutSeq);
      end
      n_cmp++;
      if (Overflow !== 1'b0 || DropCount !== 8'd0) begin
         n_err++;
         $display("FAIL streaming_drops: got ovf=%b drop=%0d, expected 0/0", Overflow, DropCount);
      end
      idle();
   endtask

   task automatic test_random();
      ent_t h;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 60), $urandom, $urandom, ($urandom_range(0, 99) < 45));
         h = (mq.size() > 0) ? mq[0] : '{pc: 32'h0, data: 32'h0, seq: 16'h0};
         n_cmp++;
         if (Count !== 5'(mq.size()) || OutValid !== (mq.size() > 0) || Full !== (mq.size() == DEPTH) ||
             OutPC !== h.pc || OutData !== h.data || OutSeq !== h.seq ||
             Overflow !== m_ovf || DropCount !== 8'(m_drops)) begin
            n_err++;
            $display("FAIL random[%0d]: got cnt=%0d pc=%h data=%h seq=%0d ovf=%b drop=%0d, expected %0d/%h/%h/%0d/%b/%0d",
                     i, Count, OutPC, OutData, OutSeq, Overflow, DropCount,
                     mq.size(), h.pc, h.data, h.seq, m_ovf, m_drops);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_commit();
      test_fill_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_saturation_async_reset();
      test_streaming();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
Write-back trace buffer that sits directly downstream of DataPath. Each cycle in which DataPath asserts RegWriteCommand, the block captures the committed {ProgramCount, WriteData} pair, tagged with a sequence number. Board-level display/debug logic drains captured entries at its own pace through a valid/pop handshake. The block is a first-word-fall-through FIFO plus sequence and drop counters.

Parameters:
DEPTH, 16, number of trace entries; power of two, at least 2
ADDR_W, 4, log2(DEPTH)
SEQ_W, 16, width of the per-commit sequence counter

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-high reset
RegWriteCommand  input  1  DataPath register-write strobe; one commit per cycle high
WriteData  input  32  DataPath write-back value
ProgramCount  input  32  DataPath PC of the committing instruction
Pop  input  1  consumer acknowledges the head entry
OutValid  output  1  head entry present (equals !Empty)
OutPC  output  32  head entry PC
OutData  output  32  head entry write-back value
OutSeq  output  SEQ_W  head entry sequence number
Count  output  ADDR_W+1  entries currently stored, 0..DEPTH
Empty  output  1  Count==0
Full  output  1  Count==DEPTH
Overflow  output  1  sticky; set when a commit is dropped
DropCount  output  8  number of dropped commits, saturating at 255

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation): read and write pointers 0, Count 0, Empty 1, Full 0, OutValid 0, Overflow 0, DropCount 0, sequence counter 0. OutPC, OutData and OutSeq read 0 while empty. Storage array contents are don't-care.
- Push = RegWriteCommand sampled at a Clk rising edge. Pop is effective only when OutValid=1 at that edge; a Pop while empty is ignored and has no side effects.
- Sequence counter increments on every commit, stored or dropped, and wraps from 2^SEQ_W-1 to 0. A stored entry carries the counter value before the increment, so the first commit after reset is seq 0.
- Stored and dropped commits share one sequence space, so the consumer detects losses as gaps in OutSeq.
- Latency: an entry pushed at edge N is visible at the head (OutValid=1, fields valid) after edge N when the FIFO was empty. The head updates to the next entry immediately after a Pop edge.
- Outputs are driven from registered pointers and storage only; no combinational path from Pop or RegWriteCommand to any output.
- Simultaneous push and pop:
  - Not full and not empty: both happen; Count unchanged.
  - Full: pop frees a slot and the push is stored; no drop.
  - Empty: push stored, pop ignored; Count becomes 1.
- Push while Full with no effective Pop: entry discarded, Overflow set to 1 (sticky until Reset), DropCount incremented unless already 255. The sequence counter still increments.
- Pointers are ADDR_W bits and wrap from DEPTH-1 to 0. Count is tracked explicitly, so Full and Empty are unambiguous.
- Count, Empty and Full update on the same edge as the push/pop that changes them.
- RTL state machine: two-bit occupancy state {EMPTY, PARTIAL, FULL}.
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL when a push without pop makes Count==DEPTH.
  - PARTIAL to EMPTY when a pop without push makes Count==0.
  - FULL to PARTIAL on pop without push.
  - All other combinations hold state.
  - Empty and Full are decoded from this state.

Test Plan:
- Reset held 4 cycles, then RegWriteCommand=1 one cycle with PC=0x00000004, WriteData=0x0000002A -> next cycle OutValid=1, OutPC=0x4, OutData=0x2A, OutSeq=0, Count=1.
- 16 back-to-back commits (PC 0x0..0x3C step 4, data=i), no Pop -> Full=1, Count=16. A 17th commit -> Overflow=1, DropCount=1, Count stays 16. Drain all 16 -> OutSeq 0..15 in order, head data 0..15. The next stored commit gets OutSeq=17.
- While Full, commit and Pop in the same cycle -> Count stays 16, Overflow stays 0, new entry appears last in drain order.
- While Empty, commit and Pop in the same cycle -> Count=1, entry retained. Pop with no commit while empty -> Count stays 0, no pointer movement.
- 300 commits with no Pop -> DropCount saturates at 255 (284 drops attempted), Overflow=1. Assert Reset mid-stream, asynchronously between edges -> all outputs return to reset values before the next edge.
- Streaming test: commit every cycle and Pop every cycle for 40 cycles -> Count oscillates within 0..1, pointers wrap twice, OutSeq strictly increments by 1, no drops.
